// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared op/state encodings and default latencies for the mult/div scheduler
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } md_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - combinational signed/unsigned multiply and divide producing {hi,lo}
module muldiv_core
    import cpu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic signed [31:0] s_quot;
    logic signed [31:0] s_rem;
    logic        [31:0] u_quot;
    logic        [31:0] u_rem;
    logic               b_zero;

    assign b_zero = (b == 32'd0);
    assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign u_prod = {32'd0, a} * {32'd0, b};

    // Divide-by-zero is masked to 0 here; the scheduler suppresses its commit anyway.
    assign s_quot = b_zero ? 32'sd0 : $signed(a) / $signed(b);
    assign s_rem  = b_zero ? 32'sd0 : $signed(a) % $signed(b);
    assign u_quot = b_zero ? 32'd0 : a / b;
    assign u_rem  = b_zero ? 32'd0 : a % b;

    always_comb begin
        result = 64'd0;
        case (op)
            OP_MULT:  result = s_prod;
            OP_MULTU: result = u_prod;
            OP_DIV:   result = {s_rem, s_quot};
            OP_DIVU:  result = {u_rem, u_quot};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - multi-cycle mult/div scheduler owning the architectural HI/LO registers
module muldiv_sched
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        we,
    input  logic        hilo,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        interupt,
    input  logic        clear_xalu,
    input  logic        d_use,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    md_state_e   state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_ok;
    logic [63:0] core_res;
    logic        issue_ok;

    muldiv_core u_core (
        .op     (op),
        .a      (d1),
        .b      (d2),
        .result (core_res)
    );

    assign busy     = (state != ST_IDLE);
    assign stall_d  = d_use & (busy | start);
    assign issue_ok = !interupt && !clear_xalu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_ok <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_ok && start) begin
                        pend_hi <= core_res[63:32];
                        pend_lo <= core_res[31:0];
                        // A zero divisor still occupies the unit but never writes HI/LO.
                        pend_ok <= !(op[1] && (d2 == 32'd0));
                        cnt     <= op[1] ? DIV_CNT : MUL_CNT;
                        state   <= op[1] ? ST_DIV : ST_MUL;
                    end else if (issue_ok && we) begin
                        if (hilo) hi <= d1;
                        else      lo <= d1;
                    end
                end
                default: begin
                    if (clear_xalu) begin
                        state   <= ST_IDLE;
                        cnt     <= 4'd0;
                        pend_hi <= 32'd0;
                        pend_lo <= 32'd0;
                        pend_ok <= 1'b0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (pend_ok) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - directed table-driven bench for muldiv_sched
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        we = 1'b0;
    logic        hilo = 1'b0;
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;
    logic        interupt = 1'b0;
    logic        clear_xalu = 1'b0;
    logic        d_use = 1'b0;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .we         (we),
        .hilo       (hilo),
        .d1         (d1),
        .d2         (d2),
        .interupt   (interupt),
        .clear_xalu (clear_xalu),
        .d_use      (d_use),
        .busy       (busy),
        .stall_d    (stall_d),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        we = 1'b1; hilo = 1'b1; d1 = h;
        tick();
        hilo = 1'b0; d1 = l;
        tick();
        we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; d1 = a; d2 = b;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles after the accept edge; gives up after 40.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{2'b00, 32'h3,        32'hFFFFFFFE, 32'h0,  32'h0,    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{2'b01, 32'h3,        32'hFFFFFFFE, 32'h0,  32'h0,    32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,    32'hFFFFFFFE, 32'h00000001, 5};
        vecs[3] = '{2'b00, 32'h80000000, 32'h80000000, 32'h0,  32'h0,    32'h40000000, 32'h00000000, 5};
        vecs[4] = '{2'b11, 32'h7,        32'h2,        32'h0,  32'h0,    32'h00000001, 32'h00000003, 10};
        vecs[5] = '{2'b10, 32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[6] = '{2'b10, 32'h7,        32'hFFFFFFFE, 32'h0,  32'h0,    32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{2'b11, 32'hFFFFFFF9, 32'h2,        32'h0,  32'h0,    32'h00000001, 32'h7FFFFFFC, 10};
        vecs[8] = '{2'b10, 32'h5,        32'h0,        32'hAAAA, 32'h1234, 32'h0000AAAA, 32'h00001234, 10};
        vecs[9] = '{2'b00, 32'h0,        32'h12345678, 32'h55, 32'h66,   32'h00000000, 32'h00000000, 5};

        // Reset state
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].pre_hi, vecs[i].pre_lo);
            check($sformatf("v%0d_pre_hi", i), hi, vecs[i].pre_hi);
            check($sformatf("v%0d_pre_lo", i), lo, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].d1, vecs[i].d2);
            count_busy(n);
            check($sformatf("v%0d_busy_cycles", i), n, vecs[i].lat);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // clear_xalu at busy cycle 3
        preload(32'h11, 32'h22);
        issue(2'b00, 32'd5, 32'd6);
        tick();
        tick();
        check("clr3_busy_before", busy, 1);
        clear_xalu = 1'b1;
        tick();
        clear_xalu = 1'b0;
        check("clr3_busy_after", busy, 0);
        repeat (8) tick();
        check("clr3_hi", hi, 32'h11);
        check("clr3_lo", lo, 32'h22);

        // clear_xalu in the last busy cycle (counter = 0)
        issue(2'b01, 32'd5, 32'd6);
        repeat (4) tick();
        check("clr0_busy_before", busy, 1);
        clear_xalu = 1'b1;
        tick();
        clear_xalu = 1'b0;
        check("clr0_busy_after", busy, 0);
        check("clr0_lo", lo, 32'h22);

        // start with interupt is suppressed
        interupt = 1'b1;
        issue(2'b00, 32'd9, 32'd9);
        interupt = 1'b0;
        check("int_busy", busy, 0);
        tick();
        check("int_lo", lo, 32'h22);

        // start beats we in the same cycle
        we = 1'b1; hilo = 1'b0;
        issue(2'b00, 32'd4, 32'd5);
        we = 1'b0;
        check("sw_busy", busy, 1);
        check("sw_lo_dropped", lo, 32'h22);
        count_busy(n);
        check("sw_cycles", n, 5);
        check("sw_hi", hi, 32'd0);
        check("sw_lo", lo, 32'd20);

        // stall_d tracking
        d_use = 1'b1;
        #1;
        check("stall_idle", stall_d, 0);
        start = 1'b1; op = 2'b11; d1 = 32'd100; d2 = 32'd7;
        #1;
        check("stall_start", stall_d, 1);
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            check($sformatf("stall_busy_c%0d", n), stall_d, 1);
            tick();
        end
        check("stall_cycles", n, 10);
        check("stall_after", stall_d, 0);
        check("stall_divu_lo", lo, 32'd14);
        check("stall_divu_hi", hi, 32'd2);
        d_use = 1'b0;

        // reset mid-DIV
        issue(2'b10, 32'd50, 32'd3);
        repeat (3) tick();
        check("rst_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        d_use = 1'b1; start = 1'b1;
        #1;
        check("rst_stall_start", stall_d, 1);
        start = 1'b0;
        #1;
        check("rst_stall_nostart", stall_d, 0);
        d_use = 1'b0;
        tick();
        rst = 1'b1;
        repeat (15) tick();
        check("rst_post_busy", busy, 0);
        check("rst_post_lo", lo, 0);
        check("rst_post_hi", hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
